// File: rtl/regfile_scoreboard.sv
// XLEN x NREG register file with NRD combinational read ports, WB->read bypass and a
// per-register pending-write scoreboard driving a decode stall. Optional REGFILE_DEBUG_EN adds debug taps.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int MAXINF = 3,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(MAXINF + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic                stall
`ifdef REGFILE_DEBUG_EN
  ,
  output logic [NREG*XLEN-1:0] dbg_regs,
  output logic [NREG-1:0]      dbg_pending
`endif
);

  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0]   cnt  [NREG];
  logic            wb_wr;
  logic            iss_fire;
  logic            stall_rd;
  logic            stall_waw;
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  assign wb_wr    = wb_valid && (wb_addr != '0);
  assign iss_fire = iss_valid && !stall && (iss_rd != '0);

  always_comb begin
    logic [AW-1:0] a;
    a        = '0;
    rd_data  = '0;
    stall_rd = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      if (a == '0)
        rd_data[i*XLEN +: XLEN] = '0;
      else if (wb_valid && wb_addr == a)
        rd_data[i*XLEN +: XLEN] = wb_data;
      else
        rd_data[i*XLEN +: XLEN] = regs[a];
      // A single outstanding write landing this cycle is served by the bypass
      if (rd_en[i] && a != '0 &&
          ((cnt[a] > CW'(1)) || (cnt[a] == CW'(1) && !(wb_valid && wb_addr == a))))
        stall_rd = 1'b1;
    end
  end

  assign stall_waw = iss_valid && (iss_rd != '0) && (cnt[iss_rd] == CW'(MAXINF)) &&
                     !(wb_valid && wb_addr == iss_rd);
  assign stall     = stall_rd || stall_waw;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_fire) inc_vec[iss_rd] = 1'b1;
    if (wb_wr)    dec_vec[wb_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wb_wr) regs[wb_addr] <= wb_data;
      for (int unsigned r = 1; r < NREG; r++) begin
        if (flush)
          cnt[r] <= '0;
        else if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CW'(1);
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

`ifdef REGFILE_DEBUG_EN
  always_comb begin
    dbg_regs    = '0;
    dbg_pending = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      dbg_regs[r*XLEN +: XLEN] = regs[r];
      dbg_pending[r]           = (cnt[r] != '0);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: vector table plus hand sequences,
// expected outputs queued at drive time and popped when the outputs are sampled.
module tb_regfile_scoreboard;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int MAXINF = 3;
  localparam int AW     = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic                stall;
`ifdef REGFILE_DEBUG_EN
  logic [NREG*XLEN-1:0] dbg_regs;
  logic [NREG-1:0]      dbg_pending;
`endif

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXINF(MAXINF)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .stall(stall)
`ifdef REGFILE_DEBUG_EN
    , .dbg_regs(dbg_regs), .dbg_pending(dbg_pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            st;
    logic [XLEN-1:0] r0;
    logic [XLEN-1:0] r1;
  } exp_t;

  typedef struct {
    logic [1:0]      en;
    logic [AW-1:0]   a0, a1;
    logic            iv;
    logic [AW-1:0]   ird;
    logic            wv;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            fl;
    logic            st;
    logic [XLEN-1:0] r0, r1;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[20];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.st});
    chk({e.name, ".rd0"}, rd_data[0 +: XLEN], e.r0);
    chk({e.name, ".rd1"}, rd_data[XLEN +: XLEN], e.r1);
  endtask

  // Drive one cycle of stimulus at negedge, queue the expectation, sample before posedge.
  task automatic run(input string nm, input vec_t v);
    exp_t e;
    @(negedge clk);
    rd_en     = v.en;
    rd_addr   = {v.a1, v.a0};
    iss_valid = v.iv;
    iss_rd    = v.ird;
    wb_valid  = v.wv;
    wb_addr   = v.wa;
    wb_data   = v.wd;
    flush     = v.fl;
    e.name = nm; e.st = v.st; e.r0 = v.r0; e.r1 = v.r1;
    exp_q.push_back(e);
    #2;
    sample();
  endtask

  // en, a0, a1, iv, ird, wv, wa, wd, fl, exp stall, exp rd0, exp rd1
  function automatic vec_t mk(input logic [1:0] en, input int a0, input int a1,
                              input logic iv, input int ird, input logic wv, input int wa,
                              input logic [XLEN-1:0] wd, input logic fl, input logic st,
                              input logic [XLEN-1:0] r0, input logic [XLEN-1:0] r1);
    vec_t v;
    v.en = en; v.a0 = AW'(a0); v.a1 = AW'(a1); v.iv = iv; v.ird = AW'(ird);
    v.wv = wv; v.wa = AW'(wa); v.wd = wd; v.fl = fl; v.st = st; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_en = '0; rd_addr = '0; iss_valid = 0; iss_rd = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;

    // Bypass / x0
    tbl[0]  = mk(2'b00, 7, 0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(2'b11, 7, 7, 0, 0, 0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    tbl[2]  = mk(2'b11, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 32'h0, 32'h0);
    tbl[3]  = mk(2'b11, 0, 7, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'hDEADBEEF);
    // RAW on x3, with and without rd_en
    tbl[4]  = mk(2'b00, 3, 0, 1, 3, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    tbl[5]  = mk(2'b01, 3, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0);
    tbl[6]  = mk(2'b01, 3, 0, 0, 0, 1, 3, 32'h12, 0, 0, 32'h12, 32'h0);
    tbl[7]  = mk(2'b01, 3, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h12, 32'h0);
    tbl[8]  = mk(2'b00, 0, 0, 1, 3, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    tbl[9]  = mk(2'b00, 3, 3, 0, 0, 0, 0, 32'h0, 0, 0, 32'h12, 32'h12);
    tbl[10] = mk(2'b00, 3, 0, 0, 0, 1, 3, 32'h34, 0, 0, 32'h34, 32'h0);
    // Simultaneous issue+wb on x9, wb with cnt=0
    tbl[11] = mk(2'b00, 0, 0, 1, 9, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    tbl[12] = mk(2'b00, 0, 9, 1, 9, 1, 9, 32'h99, 0, 0, 32'h0, 32'h99);
    tbl[13] = mk(2'b10, 0, 9, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h99);
    tbl[14] = mk(2'b10, 0, 9, 0, 0, 1, 9, 32'h9A, 0, 0, 32'h0, 32'h9A);
    tbl[15] = mk(2'b10, 0, 9, 0, 0, 1, 9, 32'h9B, 0, 0, 32'h0, 32'h9B);
    tbl[16] = mk(2'b00, 0, 0, 1, 9, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    tbl[17] = mk(2'b10, 0, 9, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h9B);
    tbl[18] = mk(2'b10, 0, 9, 0, 0, 1, 9, 32'h9C, 0, 0, 32'h0, 32'h9C);
    tbl[19] = mk(2'b11, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Reset state
    run("reset_state", mk(2'b11, 7, 3, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      run($sformatf("vec%0d", i), tbl[i]);

    // Multi-inflight on x4: the fourth issue is held off
    for (int k = 0; k < 3; k++)
      run($sformatf("mi_iss%0d", k), mk(2'b00, 0, 0, 1, 4, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("mi_iss_full", mk(2'b00, 0, 0, 1, 4, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0));
    run("mi_wb1", mk(2'b01, 4, 0, 0, 0, 1, 4, 32'hA1, 0, 1, 32'hA1, 32'h0));
    run("mi_wb2", mk(2'b01, 4, 0, 0, 0, 1, 4, 32'hA2, 0, 1, 32'hA2, 32'h0));
    run("mi_wb3", mk(2'b01, 4, 0, 0, 0, 1, 4, 32'hA3, 0, 0, 32'hA3, 32'h0));
    run("mi_after", mk(2'b01, 4, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'hA3, 32'h0));

    // Flush: cnt[2]=2, cnt[6]=1, then flush with a competing issue and a data write
    run("fl_iss2a", mk(2'b00, 0, 0, 1, 2, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("fl_iss2b", mk(2'b00, 0, 0, 1, 2, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("fl_iss6",  mk(2'b00, 0, 0, 1, 6, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("fl_pre",   mk(2'b11, 2, 6, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0));
    run("fl_flush", mk(2'b00, 0, 6, 1, 8, 1, 6, 32'h666, 1, 0, 32'h0, 32'h666));
    run("fl_post",  mk(2'b11, 2, 6, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h666));
`ifdef REGFILE_DEBUG_EN
    chk("fl_dbg_pending", dbg_pending, '0);
`endif
    run("fl_x8",    mk(2'b10, 0, 8, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("fl_wb2",   mk(2'b01, 2, 0, 0, 0, 1, 2, 32'h222, 0, 0, 32'h222, 32'h0));
    run("fl_rd2",   mk(2'b01, 2, 0, 1, 2, 0, 0, 32'h0, 0, 0, 32'h222, 32'h0));
    run("fl_raw2",  mk(2'b01, 2, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h222, 32'h0));

    // Mid-run reset with cnt[5]=2
    run("rs_iss5a", mk(2'b00, 0, 0, 1, 5, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("rs_iss5b", mk(2'b00, 0, 0, 1, 5, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    run("rs_pre",   mk(2'b11, 5, 7, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'hDEADBEEF));
    @(negedge clk);
    rst = 1'b1;
    run("rs_held",  mk(2'b11, 5, 7, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    rst = 1'b0;
    run("rs_after", mk(2'b11, 5, 7, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
